battleship_board_engine: RTL and testbench
==========================================

# battleship_board_engine

Parametrised board engine for the battleship game. It receives the ship map and the ship-life table as a byte stream from the UART receiver. It then resolves shots at (x, y) coordinates and returns a one-byte verdict to the UART transmitter. Compared with the previous game FSM, it adds:
- generic grid size and ship count;
- per-ship hit counters with a sunk report ('S');
- a win report ('W');
- a valid/ready handshake on both the shot and response sides.

## Interface
Parameters:
- X_BITS, 3, column address width; grid width = 2**X_BITS
- Y_BITS, 3, row address width; grid height = 2**Y_BITS
- N_SHIPS, 16, number of ship ids (1..N_SHIPS), at most 127
- LIFE_BITS, 4, width of each ship-life counter

Ports:
- CLOCK_50  in  1  clock; the block uses this single clock
- rst  in  1  synchronous, active-high reset
- rx_data  in  8  byte from UART RX
- rx_valid  in  1  one-cycle strobe, rx_data valid
- shot_x  in  X_BITS  target column
- shot_y  in  Y_BITS  target row
- shot_valid  in  1  shot request
- shot_ready  out  1  engine accepts a shot this cycle
- tx_data  out  8  verdict byte
- tx_valid  out  1  verdict valid, held until tx_ready
- tx_ready  in  1  UART TX accepts tx_data
- fsm_state  out  3  current state encoding
- ships_left  out  7  ships with nonzero life
- game_over  out  1  all ships sunk
- load_err  out  1  sticky: a map byte held a ship id > N_SHIPS

## Operation
- Cell RAM: 2**(X_BITS+Y_BITS) × 8 bits.
  - bit7 = shot flag.
  - bits6:0 = ship id; 0 = water.
  - Address = {y, x} (row-major).
- Life array: N_SHIPS × LIFE_BITS registers.
- States:
  - LOAD_MAP: byte k on rx_valid is written to address k with bit7 forced to 0. An id > N_SHIPS sets load_err and is stored as 0 (water). After the last cell → LOAD_LIFE.
  - LOAD_LIFE: byte j sets life[j], clamped to 2**LIFE_BITS-1. A nonzero value increments ships_left. After N_SHIPS bytes → PLAYING, or → GAME_OVER if ships_left = 0.
  - PLAYING: shot_ready=1. When shot_valid & shot_ready, latch x/y and issue the RAM read → EVAL.
  - EVAL: compute the verdict from the registered RAM word.
    - bit7 set → 'R' (0x52), no write.
    - id = 0 → 'M' (0x4D); set bit7.
    - id ≠ 0 → set bit7; if life[id-1] > 1, decrement → 'H' (0x48).
    - id ≠ 0 and life[id-1] = 1 → life becomes 0, ships_left−1 → 'S' (0x53), or 'W' (0x57) when ships_left reaches 0.
    - id ≠ 0 and life[id-1] = 0 already → 'H', no decrement, ships_left unchanged.
    - The write-back is in the same cycle → RESPOND.
  - RESPOND: tx_valid=1. On tx_ready → PLAYING, or → GAME_OVER after 'W'.
  - GAME_OVER: game_over=1, shot_ready=0. Stays here until rst.
- rx_valid is ignored outside the LOAD states. shot_valid is ignored outside PLAYING.

## Timing
- Reset values:
  - fsm_state = LOAD_MAP
  - shot_ready = 0
  - tx_valid = 0
  - tx_data = 0x00
  - ships_left = 0
  - game_over = 0
  - load_err = 0
  - load counters = 0
  - life array = 0
- RAM contents are not cleared by rst; the next load overwrites them.
- Load: one byte per rx_valid. The write occurs on the same edge.
- Shot latency:
  - Accept edge T.
  - RAM data registered at T+1.
  - EVAL and write-back at T+2.
  - tx_valid high from T+3.
- Response handshake: tx_data is stable while tx_valid=1. The transfer completes on the edge where tx_valid & tx_ready. shot_ready is high again on the following cycle.
- A shot_valid held across a response is not re-accepted until shot_ready returns.
- rst mid-shot or mid-load: the block returns to LOAD_MAP on the next edge. Any pending verdict is dropped.
- rx_valid coinciding with the last LOAD_LIFE byte: that byte completes the load. Later bytes are ignored.

## Structure
- battleship_pkg holds:
  - state encodings: LOAD_MAP=0, LOAD_LIFE=1, PLAYING=2, EVAL=3, RESPOND=4, GAME_OVER=5 (one extra read-wait code if needed);
  - response constants: RESP_MISS, RESP_HIT, RESP_REPEAT, RESP_SUNK, RESP_WIN.
- Sub-module board_ram: single-port RAM, synchronous write, registered read, parametrised on address width. It infers block RAM.

## Test plan
- Default parameters. Map with id 1 at cells 2,4,6,8,10 (all others 0); lives = 5,0,…,0. Result: PLAYING, ships_left=1.
- Shot (2,0) → 'H' (0x48) with tx_valid at T+3. Repeat the shot → 'R' (0x52).
- Shot (3,0) → 'M'. Shots at cells 4,6,8,10 → 'H','H','H','W'. Then game_over=1 and shot_ready=0.
- Two ships, lives 1 and 2 → the first hit on ship 1 returns 'S' and ships_left drops from 2 to 1.
- tx_ready held low for 20 cycles → tx_valid/tx_data stable, no new shot accepted.
- Map byte 0x7F during load → load_err=1 and that cell answers 'M'. rst asserted while in EVAL → LOAD_MAP next cycle, tx_valid=0.

Source files
------------

// File: rtl/battleship_pkg.sv
// Shared state encodings and verdict bytes for the battleship board engine.
package battleship_pkg;

  typedef enum logic [2:0] {
    ST_LOAD_MAP  = 3'd0,
    ST_LOAD_LIFE = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_EVAL      = 3'd3,
    ST_RESPOND   = 3'd4,
    ST_GAME_OVER = 3'd5,
    ST_READ_WAIT = 3'd6
  } state_t;

  localparam logic [7:0] RESP_MISS   = 8'h4D;  // 'M'
  localparam logic [7:0] RESP_HIT    = 8'h48;  // 'H'
  localparam logic [7:0] RESP_REPEAT = 8'h52;  // 'R'
  localparam logic [7:0] RESP_SUNK   = 8'h53;  // 'S'
  localparam logic [7:0] RESP_WIN    = 8'h57;  // 'W'

endpackage

// File: rtl/board_ram.sv
// Single-port cell RAM: synchronous write, registered read-first output.
module board_ram #(
  parameter int ADDR_BITS = 6,
  parameter int DATA_BITS = 8
) (
  input  logic                 clk,
  input  logic                 we,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  output logic [DATA_BITS-1:0] rdata
);

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= mem[addr];
  end

endmodule

// File: rtl/battleship_board_engine.sv
// Loads the ship map and life table from the UART byte stream, then resolves
// shots into one-byte verdicts with valid/ready handshakes on both sides.
//
// state      | meaning
// LOAD_MAP   | writing map bytes to cells 0..2**(X+Y)-1
// LOAD_LIFE  | writing ship lives 1..N_SHIPS, counting live ships
// PLAYING    | shot_ready high, waiting for a shot
// READ_WAIT  | RAM read of the latched cell in flight
// EVAL       | verdict computed, cell and life written back
// RESPOND    | tx_valid high until tx_ready
// GAME_OVER  | all ships sunk, idle until rst
module battleship_board_engine
  import battleship_pkg::*;
#(
  parameter int X_BITS    = 3,
  parameter int Y_BITS    = 3,
  parameter int N_SHIPS   = 16,
  parameter int LIFE_BITS = 4
) (
  input  logic              CLOCK_50,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic [X_BITS-1:0] shot_x,
  input  logic [Y_BITS-1:0] shot_y,
  input  logic              shot_valid,
  output logic              shot_ready,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [2:0]        fsm_state,
  output logic [6:0]        ships_left,
  output logic              game_over,
  output logic              load_err
);

  localparam int ADDR_BITS = X_BITS + Y_BITS;
  localparam int IDX_BITS  = (N_SHIPS > 1) ? $clog2(N_SHIPS) : 1;
  localparam int LIFE_MAX  = (1 << LIFE_BITS) - 1;

  state_t                 state;
  logic [ADDR_BITS-1:0]   map_cnt;
  logic [IDX_BITS-1:0]    life_cnt;
  logic [X_BITS-1:0]      lat_x;
  logic [Y_BITS-1:0]      lat_y;
  logic [LIFE_BITS-1:0]   life [N_SHIPS];

  logic                   ram_we;
  logic [ADDR_BITS-1:0]   ram_addr;
  logic [7:0]             ram_wdata;
  logic [7:0]             ram_rdata;

  logic                   load_bad;
  logic [6:0]             load_id;
  logic [LIFE_BITS-1:0]   life_in;
  logic [6:0]             left_inc;
  logic [6:0]             hit_id;
  logic [IDX_BITS-1:0]    hit_idx;
  logic [LIFE_BITS-1:0]   hit_life;

  always_comb begin
    load_bad = rx_data[6:0] > 7'(N_SHIPS);
    load_id  = load_bad ? 7'd0 : rx_data[6:0];
    life_in  = (int'(rx_data) > LIFE_MAX) ? LIFE_BITS'(LIFE_MAX) : LIFE_BITS'(rx_data);
    left_inc = ships_left + 7'(rx_data != 8'd0);
    hit_id   = ram_rdata[6:0];
    hit_idx  = IDX_BITS'(hit_id - 7'd1);
    // An out-of-range id can only come from stale RAM; treat it as lifeless.
    hit_life = (hit_id != 7'd0 && hit_id <= 7'(N_SHIPS)) ? life[hit_idx] : '0;

    ram_addr  = (state == ST_LOAD_MAP) ? map_cnt : {lat_y, lat_x};
    ram_we    = ((state == ST_LOAD_MAP) && rx_valid) ||
                ((state == ST_EVAL) && !ram_rdata[7]);
    ram_wdata = (state == ST_LOAD_MAP) ? {1'b0, load_id} : {1'b1, hit_id};
  end

  board_ram #(.ADDR_BITS(ADDR_BITS), .DATA_BITS(8)) u_ram (
    .clk   (CLOCK_50),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign fsm_state = state;

  always_ff @(posedge CLOCK_50) begin
    if (rst) begin
      state      <= ST_LOAD_MAP;
      shot_ready <= 1'b0;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      ships_left <= 7'd0;
      game_over  <= 1'b0;
      load_err   <= 1'b0;
      map_cnt    <= '0;
      life_cnt   <= '0;
      lat_x      <= '0;
      lat_y      <= '0;
      for (int i = 0; i < N_SHIPS; i++) life[i] <= '0;
    end else begin
      case (state)
        ST_LOAD_MAP: begin
          if (rx_valid) begin
            if (load_bad) load_err <= 1'b1;
            map_cnt <= map_cnt + 1'b1;
            if (&map_cnt) state <= ST_LOAD_LIFE;
          end
        end

        ST_LOAD_LIFE: begin
          if (rx_valid) begin
            life[life_cnt] <= life_in;
            ships_left     <= left_inc;
            if (life_cnt == IDX_BITS'(N_SHIPS - 1)) begin
              life_cnt <= '0;
              if (left_inc == 7'd0) begin
                state     <= ST_GAME_OVER;
                game_over <= 1'b1;
              end else begin
                state      <= ST_PLAYING;
                shot_ready <= 1'b1;
              end
            end else begin
              life_cnt <= life_cnt + 1'b1;
            end
          end
        end

        ST_PLAYING: begin
          if (shot_valid && shot_ready) begin
            lat_x      <= shot_x;
            lat_y      <= shot_y;
            shot_ready <= 1'b0;
            state      <= ST_READ_WAIT;
          end
        end

        ST_READ_WAIT: state <= ST_EVAL;

        ST_EVAL: begin
          if (ram_rdata[7]) begin
            tx_data <= RESP_REPEAT;
          end else if (hit_id == 7'd0) begin
            tx_data <= RESP_MISS;
          end else if (hit_life > LIFE_BITS'(1)) begin
            life[hit_idx] <= hit_life - 1'b1;
            tx_data       <= RESP_HIT;
          end else if (hit_life == LIFE_BITS'(1)) begin
            life[hit_idx] <= '0;
            ships_left    <= ships_left - 7'd1;
            tx_data       <= (ships_left == 7'd1) ? RESP_WIN : RESP_SUNK;
          end else begin
            tx_data <= RESP_HIT;
          end
          tx_valid <= 1'b1;
          state    <= ST_RESPOND;
        end

        ST_RESPOND: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            if (tx_data == RESP_WIN) begin
              state     <= ST_GAME_OVER;
              game_over <= 1'b1;
            end else begin
              state      <= ST_PLAYING;
              shot_ready <= 1'b1;
            end
          end
        end

        ST_GAME_OVER: begin
          shot_ready <= 1'b0;
          game_over  <= 1'b1;
        end

        default: state <= ST_LOAD_MAP;
      endcase
    end
  end

endmodule

// File: tb/tb_battleship_board_engine.sv
// Directed bench: loads boards over rx, fires shots, scoreboards the verdicts.
module tb_battleship_board_engine;
  import battleship_pkg::*;

  logic       CLOCK_50 = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [2:0] shot_x = '0;
  logic [2:0] shot_y = '0;
  logic       shot_valid = 1'b0;
  logic       shot_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [2:0] fsm_state;
  logic [6:0] ships_left;
  logic       game_over;
  logic       load_err;

  battleship_board_engine dut (
    .CLOCK_50   (CLOCK_50),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .shot_x     (shot_x),
    .shot_y     (shot_y),
    .shot_valid (shot_valid),
    .shot_ready (shot_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .fsm_state  (fsm_state),
    .ships_left (ships_left),
    .game_over  (game_over),
    .load_err   (load_err)
  );

  always #10 CLOCK_50 = ~CLOCK_50;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] map_buf [64];
  logic [7:0] life_buf [16];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    rst = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge CLOCK_50);
    rx_valid = 1'b0;
  endtask

  task automatic load_board();
    for (int i = 0; i < 64; i++) send_byte(map_buf[i]);
    for (int i = 0; i < 16; i++) send_byte(life_buf[i]);
  endtask

  task automatic clear_bufs();
    for (int i = 0; i < 64; i++) map_buf[i] = 8'h00;
    for (int i = 0; i < 16; i++) life_buf[i] = 8'h00;
  endtask

  // Fire one shot, await the verdict, and complete the handshake.
  task automatic shot(input int x, input int y, input logic [7:0] exp, input bit chk_lat);
    int n;
    exp_q.push_back(exp);
    n = 0;
    while (!shot_ready && n < 50) begin @(negedge CLOCK_50); n++; end
    check("shot_ready_before", 32'(shot_ready), 32'd1);
    shot_x = 3'(x);
    shot_y = 3'(y);
    shot_valid = 1'b1;
    @(posedge CLOCK_50);
    #1 shot_valid = 1'b0;
    n = 0;
    do begin @(negedge CLOCK_50); n++; end while (!tx_valid && n < 50);
    check("tx_valid_rise", 32'(tx_valid), 32'd1);
    if (chk_lat) check("latency", 32'(n), 32'd3);
    check($sformatf("verdict(%0d,%0d)", x, y), 32'(tx_data), 32'(exp_q.pop_front()));
    tx_ready = 1'b1;
    @(negedge CLOCK_50);
    tx_ready = 1'b0;
    check("tx_valid_drop", 32'(tx_valid), 32'd0);
  endtask

  task automatic map_a(input logic [7:0] life0);
    clear_bufs();
    map_buf[2] = 8'd1; map_buf[4] = 8'd1; map_buf[6] = 8'd1;
    map_buf[8] = 8'd1; map_buf[10] = 8'd1;
    life_buf[0] = life0;
  endtask

  initial begin
    int n;
    logic [7:0] held;

    // Reset state
    do_reset();
    check("rst_state", 32'(fsm_state), 32'(ST_LOAD_MAP));
    check("rst_shot_ready", 32'(shot_ready), 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_ships_left", 32'(ships_left), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    check("rst_load_err", 32'(load_err), 32'd0);

    // Board A: one ship of five cells
    map_a(8'd5);
    load_board();
    check("a_state", 32'(fsm_state), 32'(ST_PLAYING));
    check("a_ships_left", 32'(ships_left), 32'd1);
    check("a_load_err", 32'(load_err), 32'd0);
    send_byte(8'h01);
    send_byte(8'h7F);
    check("rx_ignored_playing", 32'(fsm_state), 32'(ST_PLAYING));

    shot(2, 0, RESP_HIT, 1'b1);
    check("shot_ready_after", 32'(shot_ready), 32'd1);
    shot(2, 0, RESP_REPEAT, 1'b1);
    shot(3, 0, RESP_MISS, 1'b0);
    shot(4, 0, RESP_HIT, 1'b0);
    shot(6, 0, RESP_HIT, 1'b0);
    shot(0, 1, RESP_HIT, 1'b0);
    shot(2, 1, RESP_WIN, 1'b0);
    check("a_game_over", 32'(game_over), 32'd1);
    check("a_go_shot_ready", 32'(shot_ready), 32'd0);
    check("a_go_state", 32'(fsm_state), 32'(ST_GAME_OVER));
    check("a_go_ships_left", 32'(ships_left), 32'd0);
    shot_valid = 1'b1;
    repeat (5) @(negedge CLOCK_50);
    shot_valid = 1'b0;
    check("go_no_response", 32'(tx_valid), 32'd0);

    // Board B: ship1 life1, ship2 life2, ship3 life0, one bad id
    do_reset();
    clear_bufs();
    map_buf[0] = 8'd1; map_buf[1] = 8'd2; map_buf[9] = 8'd2;
    map_buf[5] = 8'h7F; map_buf[12] = 8'd3;
    life_buf[0] = 8'd1; life_buf[1] = 8'd2;
    load_board();
    check("b_load_err", 32'(load_err), 32'd1);
    check("b_ships_left", 32'(ships_left), 32'd2);
    shot(0, 0, RESP_SUNK, 1'b0);
    check("b_sunk_left", 32'(ships_left), 32'd1);
    shot(5, 0, RESP_MISS, 1'b0);

    // Stalled response with shot_valid held high
    exp_q.push_back(RESP_HIT);
    shot_x = 3'd1; shot_y = 3'd0; shot_valid = 1'b1;
    @(posedge CLOCK_50);
    n = 0;
    do begin @(negedge CLOCK_50); n++; end while (!tx_valid && n < 50);
    check("stall_rise", 32'(tx_valid), 32'd1);
    held = exp_q.pop_front();
    check("stall_verdict", 32'(tx_data), 32'(held));
    for (int i = 0; i < 20; i++) begin
      @(negedge CLOCK_50);
      check("stall_valid", 32'(tx_valid), 32'd1);
      check("stall_data", 32'(tx_data), 32'(held));
      check("stall_no_accept", 32'(fsm_state), 32'(ST_RESPOND));
    end
    shot_valid = 1'b0;
    tx_ready = 1'b1;
    @(negedge CLOCK_50);
    tx_ready = 1'b0;
    check("stall_ready_back", 32'(shot_ready), 32'd1);

    shot(4, 1, RESP_HIT, 1'b0);
    check("b_dead_ship_left", 32'(ships_left), 32'd1);
    shot(1, 1, RESP_WIN, 1'b0);
    check("b_game_over", 32'(game_over), 32'd1);

    // Reset while in EVAL
    do_reset();
    map_a(8'd5);
    load_board();
    shot_x = 3'd2; shot_y = 3'd0; shot_valid = 1'b1;
    @(posedge CLOCK_50);
    #1 shot_valid = 1'b0;
    @(posedge CLOCK_50);
    @(negedge CLOCK_50);
    check("in_eval", 32'(fsm_state), 32'(ST_EVAL));
    rst = 1'b1;
    @(negedge CLOCK_50);
    rst = 1'b0;
    check("eval_rst_state", 32'(fsm_state), 32'(ST_LOAD_MAP));
    check("eval_rst_tx_valid", 32'(tx_valid), 32'd0);

    // All lives zero: straight to game over
    map_a(8'd0);
    load_board();
    check("zero_life_state", 32'(fsm_state), 32'(ST_GAME_OVER));
    check("zero_life_game_over", 32'(game_over), 32'd1);
    check("zero_life_left", 32'(ships_left), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
